// File: rtl/logic_gate_pkg.sv
// Shared types and the bitwise operation used by the gate pipeline.
// MAX_W is the widest operand supported; narrower users zero-extend and truncate.
package logic_gate_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   function automatic logic [MAX_W-1:0] logic_op(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input op_e              op);
      logic [MAX_W-1:0] r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         OP_NOTA: r = ~a;
         OP_PASS: r = a;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One valid/ready register slice. The parent computes ld_en (this slice's ready);
// valid follows upstream on load, data only captures real beats.
module logic_pipe_stage #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld_en,
   input  logic          up_valid,
   input  logic [DW-1:0] up_data,
   output logic          vld,
   output logic [DW-1:0] data
);

   logic          vld_q, vld_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (ld_en) begin
         vld_d = up_valid;
         if (up_valid) begin
            data_d = up_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld  = vld_q;
   assign data = data_q;

endmodule

// File: rtl/logic_gate_pipe.sv
// Pipelined bitwise gate: op decode, STAGES valid/ready slices carrying {y_par,y},
// and a saturating counter of delivered result beats.
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_par,
   output logic [CNT_W-1:0] op_count
);

   localparam int DW = WIDTH + 1;

   logic [MAX_W-1:0]  a_ext, b_ext;
   logic [WIDTH-1:0]  res;
   logic [DW-1:0]     in_data;
   logic [STAGES-1:0] st_vld;
   logic [DW-1:0]     st_dat [STAGES];
   logic [STAGES-1:0] rdy;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      a_ext = '0;
      b_ext = '0;
      a_ext[WIDTH-1:0] = a;
      b_ext[WIDTH-1:0] = b;
      res     = WIDTH'(logic_op(a_ext, b_ext, op_e'(op)));
      in_data = {^res, res};
   end

   // A slice is ready when some slice at or after it is empty, or the consumer takes the head.
   // Valid/ready: a beat moves on any edge where valid and ready are both high.
   generate
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         logic          up_v;
         logic [DW-1:0] up_d;

         assign rdy[i] = out_ready | ~(&st_vld[STAGES-1:i]);

         if (i == 0) begin : g_first
            assign up_v = in_valid;
            assign up_d = in_data;
         end else begin : g_rest
            assign up_v = st_vld[i-1];
            assign up_d = st_dat[i-1];
         end

         logic_pipe_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .ld_en    (rdy[i]),
            .up_valid (up_v),
            .up_data  (up_d),
            .vld      (st_vld[i]),
            .data     (st_dat[i])
         );
      end
   endgenerate

   assign in_ready      = rdy[0];
   assign out_valid     = st_vld[STAGES-1];
   assign {y_par, y}    = st_dat[STAGES-1];

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign op_count = cnt_q;

endmodule
